// File: rtl/conv_stream_if.sv
// ============================================================================
// Module   : conv_stream_if
// Desc     : Coefficient, pixel and result valid/ready streams of the engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv_stream_if #(
    parameter int INWIDTH = 16
);
    logic               fil_valid;
    logic               fil_ready;
    logic [INWIDTH-1:0] fil_data;
    logic               di_valid;
    logic               di_ready;
    logic [INWIDTH-1:0] di_data;
    logic               do_valid;
    logic               do_ready;
    logic [INWIDTH-1:0] do_data;

    modport master (
        output fil_valid, fil_data, di_valid, di_data, do_ready,
        input  fil_ready, di_ready, do_valid, do_data
    );

    modport slave (
        input  fil_valid, fil_data, di_valid, di_data, do_ready,
        output fil_ready, di_ready, do_valid, do_data
    );
endinterface

`default_nettype wire

// File: rtl/conv_stream_engine.sv
// ============================================================================
// Module   : conv_stream_engine
// Desc     : Streaming 2-D correlation with serial coefficient load and a
//            line-buffered sliding window. Define RELU_EN to clamp negatives.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_stream_engine #(
    parameter int INWIDTH = 16,
    parameter int IN_FRAC = 12,
    parameter int DI_W    = 7,
    parameter int DI_H    = 7,
    parameter int FIL_S   = 3
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       start,
    output logic            busy,
    output logic            done,
    conv_stream_if.slave    bus
);
    localparam int DO_W     = DI_W - FIL_S + 1;
    localparam int DO_H     = DI_H - FIL_S + 1;
    localparam int c_ntap   = FIL_S * FIL_S;
    localparam int c_sr_len = (FIL_S - 1) * DI_W + FIL_S - 1;
    localparam int c_sr_d   = (c_sr_len > 0) ? c_sr_len : 1;
    localparam int c_pw     = 2 * INWIDTH;
    localparam int c_acc_w  = c_pw + $clog2(c_ntap);
    localparam int c_fw     = $clog2(c_ntap + 1);
    localparam int c_cw     = $clog2(DI_W + 1);
    localparam int c_rw     = $clog2(DI_H + 1);

    localparam logic [c_fw-1:0] c_fil_last = c_fw'(c_ntap - 1);
    localparam logic [c_cw-1:0] c_col_last = c_cw'(DI_W - 1);
    localparam logic [c_rw-1:0] c_row_last = c_rw'(DI_H - 1);
    localparam logic [c_cw-1:0] c_col_min  = c_cw'(FIL_S - 1);
    localparam logic [c_rw-1:0] c_row_min  = c_rw'(FIL_S - 1);
    localparam logic signed [c_acc_w-1:0] c_max = c_acc_w'((2 ** (INWIDTH - 1)) - 1);
    localparam logic signed [c_acc_w-1:0] c_min = ~c_max;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_FIL = 2'd1,
        STREAM   = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    state_t r_state, w_next;

    logic                       w_fil_ready, w_di_ready, w_finish;
    logic                       w_fil_acc, w_di_acc, w_load, w_last_pix;
    logic [c_fw-1:0]            r_fil_cnt;
    logic [c_cw-1:0]            r_col;
    logic [c_rw-1:0]            r_row;
    logic signed [INWIDTH-1:0]  r_coef [c_ntap];
    logic signed [INWIDTH-1:0]  r_sr   [c_sr_d];
    logic signed [INWIDTH-1:0]  w_win  [c_sr_len+1];
    logic signed [c_pw-1:0]     w_prod;
    logic signed [c_acc_w-1:0]  w_acc, w_shift;
    logic [INWIDTH-1:0]         w_res;
    logic                       r_do_valid, r_done;
    logic [INWIDTH-1:0]         r_do_data;

    assign w_fil_acc  = bus.fil_valid && w_fil_ready;
    assign w_di_acc   = bus.di_valid && w_di_ready;
    assign w_last_pix = (r_row == c_row_last) && (r_col == c_col_last);
    assign w_load     = w_di_acc && (r_row >= c_row_min) && (r_col >= c_col_min);

    assign bus.fil_ready = w_fil_ready;
    assign bus.di_ready  = w_di_ready;
    assign bus.do_valid  = r_do_valid;
    assign bus.do_data   = r_do_data;
    assign busy          = (r_state != IDLE);
    assign done          = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_fil_ready = 1'b0;
        w_di_ready  = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = LOAD_FIL;
            end
            LOAD_FIL: begin
                w_fil_ready = 1'b1;
                if (bus.fil_valid && (r_fil_cnt == c_fil_last)) w_next = STREAM;
            end
            STREAM: begin
                w_di_ready = !r_do_valid || bus.do_ready;
                if (bus.di_valid && w_di_ready && w_last_pix) begin
                    // Holding register is free whenever a pixel is taken, so
                    // a last pixel that produces nothing may finish at once.
                    if (w_load) begin
                        w_next = FLUSH;
                    end else begin
                        w_next   = IDLE;
                        w_finish = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (!r_do_valid || bus.do_ready) begin
                    w_next   = IDLE;
                    w_finish = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Tap 0 is the pixel being accepted so the result for it is ready this edge.
    always_comb begin
        w_win[0] = bus.di_data;
        for (int k = 1; k <= c_sr_len; k++) w_win[k] = r_sr[k-1];
        w_prod = '0;
        w_acc  = '0;
        for (int a = 0; a < FIL_S; a++) begin
            for (int b = 0; b < FIL_S; b++) begin
                w_prod = c_pw'(r_coef[a*FIL_S+b]) * c_pw'(w_win[(FIL_S-1-a)*DI_W + (FIL_S-1-b)]);
                w_acc  = w_acc + c_acc_w'(w_prod);
            end
        end
        w_shift = w_acc >>> IN_FRAC;
        if (w_shift > c_max)      w_res = c_max[INWIDTH-1:0];
        else if (w_shift < c_min) w_res = c_min[INWIDTH-1:0];
        else                      w_res = w_shift[INWIDTH-1:0];
`ifdef RELU_EN
        if (w_res[INWIDTH-1]) w_res = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fil_cnt  <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_do_valid <= 1'b0;
            r_do_data  <= '0;
            r_done     <= 1'b0;
            for (int k = 0; k < c_ntap; k++) r_coef[k] <= '0;
            for (int k = 0; k < c_sr_d; k++) r_sr[k] <= '0;
        end else begin
            r_done <= w_finish;
            if (w_fil_acc) begin
                r_coef[r_fil_cnt] <= bus.fil_data;
                r_fil_cnt         <= (r_fil_cnt == c_fil_last) ? '0 : r_fil_cnt + 1'b1;
            end
            if (w_di_acc) begin
                r_sr[0] <= bus.di_data;
                for (int k = 1; k < c_sr_len; k++) r_sr[k] <= r_sr[k-1];
                if (r_col == c_col_last) begin
                    r_col <= '0;
                    r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_load) begin
                r_do_valid <= 1'b1;
                r_do_data  <= w_res;
            end else if (bus.do_ready) begin
                r_do_valid <= 1'b0;
            end
        end
    end
endmodule

`default_nettype wire
